// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-port memory arbiter.
// Holds the default data/address width and the arbiter FSM state encoding.
package mem_arb_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ACCESS_A = 3'd1;
    localparam logic [2:0] ST_ACCESS_B = 3'd2;
    localparam logic [2:0] ST_RESP_A   = 3'd3;
    localparam logic [2:0] ST_RESP_B   = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        ACCESS_A = ST_ACCESS_A,
        ACCESS_B = ST_ACCESS_B,
        RESP_A   = ST_RESP_A,
        RESP_B   = ST_RESP_B
    } arb_state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between a CPU
// port (a_) and a secondary port (b_). Writes take 2 cycles, reads 3.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             a_req,
    input  logic             a_we,
    input  logic [WIDTH-1:0] a_addr,
    input  logic [WIDTH-1:0] a_wdata,
    output logic             a_gnt,
    output logic [WIDTH-1:0] a_rdata,
    output logic             a_rvalid,

    input  logic             b_req,
    input  logic             b_we,
    input  logic [WIDTH-1:0] b_addr,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             b_gnt,
    output logic [WIDTH-1:0] b_rdata,
    output logic             b_rvalid,

    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,

    output logic [2:0]       o_dbg_state
);

    // Handshake: a requester raises req with we/addr/wdata and holds them stable
    // until it sees its gnt pulse; requests are only sampled in IDLE, so a req
    // dropped before gnt is simply forgotten. Read data arrives later as a
    // one-cycle rvalid pulse with rdata, which then holds until the next read.

    arb_state_e       r_state;
    arb_state_e       w_next_state;
    port_e            r_last_served;
    logic             w_grant_a;
    logic             w_grant_b;

    logic             r_we;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_a_rdata;
    logic [WIDTH-1:0] r_b_rdata;
    logic             r_a_rvalid;
    logic             r_b_rvalid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // On a tie the port that was not served last wins.
    always_comb begin
        w_next_state = r_state;
        w_grant_a    = 1'b0;
        w_grant_b    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (a_req && (!b_req || (r_last_served == PORT_B))) begin
                    w_grant_a    = 1'b1;
                    w_next_state = ACCESS_A;
                end else if (b_req) begin
                    w_grant_b    = 1'b1;
                    w_next_state = ACCESS_B;
                end
            end
            ACCESS_A: w_next_state = r_we ? IDLE : RESP_A;
            ACCESS_B: w_next_state = r_we ? IDLE : RESP_B;
            RESP_A:   w_next_state = IDLE;
            RESP_B:   w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_served <= PORT_B;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
        end else if (w_grant_a) begin
            r_last_served <= PORT_A;
            r_we          <= a_we;
            r_addr        <= a_addr;
            r_wdata       <= a_wdata;
        end else if (w_grant_b) begin
            r_last_served <= PORT_B;
            r_we          <= b_we;
            r_addr        <= b_addr;
            r_wdata       <= b_wdata;
        end
    end

    // The RAM output is valid during RESP_x; capture it and publish next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
        end else begin
            r_a_rvalid <= (r_state == RESP_A);
            r_b_rvalid <= (r_state == RESP_B);
            if (r_state == RESP_A) begin
                r_a_rdata <= mem_rdata;
            end
            if (r_state == RESP_B) begin
                r_b_rdata <= mem_rdata;
            end
        end
    end

    // mem_we is decoded from the async-reset state, so it falls as soon as reset rises.
    assign a_gnt       = (r_state == ACCESS_A);
    assign b_gnt       = (r_state == ACCESS_B);
    assign mem_we      = ((r_state == ACCESS_A) || (r_state == ACCESS_B)) && r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign a_rdata     = r_a_rdata;
    assign b_rdata     = r_b_rdata;
    assign a_rvalid    = r_a_rvalid;
    assign b_rvalid    = r_b_rvalid;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous RAM behind it.
// Each step advances one clock edge and observes outputs 1ns later.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic         a_req, a_we, a_gnt, a_rvalid;
    logic [W-1:0] a_addr, a_wdata, a_rdata;
    logic         b_req, b_we, b_gnt, b_rvalid;
    logic [W-1:0] b_addr, b_wdata, b_rdata;
    logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
    logic         mem_we;
    logic [2:0]   dbg_state;

    int checks = 0;
    int errors = 0;
    int cnt_a_rvalid = 0;
    int cnt_b_gnt = 0;
    int snap;

    logic [W-1:0] ram [0:255];

    mem_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .o_dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Synchronous RAM model: read data one clock after address
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[7:0]];
    end

    always @(negedge clk) begin
        if (a_rvalid) cnt_a_rvalid = cnt_a_rvalid + 1;
        if (b_gnt) cnt_b_gnt = cnt_b_gnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = '0;
        ram[8'h20] = 16'h1234;
        ram[8'h30] = 16'hABCD;
        ram[8'h50] = 16'h5555;
        mem_rdata = '0;
        reset = 1'b1;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        #22;

        // Reset values
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_a_gnt", a_gnt, 1'b0);
        check("rst_b_gnt", b_gnt, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_wdata", mem_wdata, 16'h0000);
        check("rst_a_rdata", a_rdata, 16'h0000);
        check("rst_b_rvalid", b_rvalid, 1'b0);
        step();
        reset = 1'b0;

        // A writes 0xBEEF to 0x0010
        a_req = 1; a_we = 1; a_addr = 16'h0010; a_wdata = 16'hBEEF;
        #1;
        check("wr_no_comb_gnt", a_gnt, 1'b0);
        check("wr_no_comb_addr", mem_addr, 16'h0000);
        step();
        check("wr_a_gnt", a_gnt, 1'b1);
        check("wr_mem_we", mem_we, 1'b1);
        check("wr_mem_addr", mem_addr, 16'h0010);
        check("wr_mem_wdata", mem_wdata, 16'hBEEF);
        a_req = 0;
        step();
        check("wr_idle", dbg_state, ST_IDLE);
        check("wr_gnt_drop", a_gnt, 1'b0);
        check("wr_we_drop", mem_we, 1'b0);
        check("wr_addr_hold", mem_addr, 16'h0010);

        // B reads back 0x0010
        b_req = 1; b_we = 0; b_addr = 16'h0010;
        step();
        check("rd_b_gnt", b_gnt, 1'b1);
        check("rd_a_gnt", a_gnt, 1'b0);
        check("rd_mem_we", mem_we, 1'b0);
        b_req = 0;
        step();
        check("rd_resp_state", dbg_state, ST_RESP_B);
        check("rd_b_rvalid_early", b_rvalid, 1'b0);
        step();
        check("rd_b_rvalid", b_rvalid, 1'b1);
        check("rd_b_rdata", b_rdata, 16'hBEEF);
        check("rd_a_rvalid", a_rvalid, 1'b0);
        step();
        check("rd_b_rvalid_pulse", b_rvalid, 1'b0);
        check("rd_b_rdata_hold", b_rdata, 16'hBEEF);

        // Both ports hold read requests: A, B, A, B, ...
        a_req = 1; a_we = 0; a_addr = 16'h0020;
        b_req = 1; b_we = 0; b_addr = 16'h0030;
        for (int i = 0; i < 8; i++) begin
            logic exp_a;
            exp_a = (i % 2 == 0);
            step();
            check("alt_a_gnt", a_gnt, exp_a);
            check("alt_b_gnt", b_gnt, !exp_a);
            check("alt_mem_addr", mem_addr, exp_a ? 16'h0020 : 16'h0030);
            step();
            check("alt_resp", dbg_state, exp_a ? ST_RESP_A : ST_RESP_B);
            step();
            check("alt_a_rvalid", a_rvalid, exp_a);
            check("alt_b_rvalid", b_rvalid, !exp_a);
            if (exp_a) check("alt_a_rdata", a_rdata, 16'h1234);
            else       check("alt_b_rdata", b_rdata, 16'hABCD);
        end
        a_req = 0; b_req = 0;
        step();

        // B request raised during an A read and withdrawn before IDLE
        a_req = 1; a_we = 0; a_addr = 16'h0020;
        snap = cnt_b_gnt;
        step();
        check("drop_a_gnt", a_gnt, 1'b1);
        a_req = 0;
        b_req = 1; b_we = 0; b_addr = 16'h0050;
        step();
        b_req = 0;
        step();
        check("drop_a_rdata", a_rdata, 16'h1234);
        step();
        step();
        check("drop_b_gnt_cnt", cnt_b_gnt, snap);
        check("drop_mem_addr", mem_addr, 16'h0020);
        check("drop_idle", dbg_state, ST_IDLE);

        // Reset during ACCESS_A of a write
        a_req = 1; a_we = 1; a_addr = 16'h0060; a_wdata = 16'h6666;
        snap = cnt_a_rvalid;
        step();
        check("rstmid_mem_we_pre", mem_we, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid_mem_we", mem_we, 1'b0);
        check("rstmid_a_gnt", a_gnt, 1'b0);
        check("rstmid_mem_addr", mem_addr, 16'h0000);
        check("rstmid_b_rdata", b_rdata, 16'h0000);
        a_req = 0;
        step();
        step();
        reset = 1'b0;
        check("rstmid_idle", dbg_state, ST_IDLE);
        check("rstmid_no_rvalid", cnt_a_rvalid, snap);
        check("rstmid_no_write", ram[8'h60], 16'h0000);

        // Simultaneous requests on the first cycle after reset: A first
        a_req = 1; a_we = 0; a_addr = 16'h0020;
        b_req = 1; b_we = 0; b_addr = 16'h0030;
        step();
        check("post_rst_a_gnt", a_gnt, 1'b1);
        check("post_rst_b_gnt", b_gnt, 1'b0);
        a_req = 0;
        step();
        step();
        check("post_rst_a_rvalid", a_rvalid, 1'b1);
        check("post_rst_a_rdata", a_rdata, 16'h1234);
        step();
        check("post_rst_b_gnt2", b_gnt, 1'b1);
        b_req = 0;
        step();
        step();
        check("post_rst_b_rvalid", b_rvalid, 1'b1);
        check("post_rst_b_rdata", b_rdata, 16'hABCD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, meaning the data and address width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port a_req, input, 1 bit: CPU access request.
REQ-005 The module SHALL have port a_we, input, 1 bit: CPU write enable (1 = write, 0 = read).
REQ-006 The module SHALL have port a_addr, input, WIDTH bits: CPU address.
REQ-007 The module SHALL have port a_wdata, input, WIDTH bits: CPU write data.
REQ-008 The module SHALL have port a_gnt, output, 1 bit: CPU request accepted (one-cycle pulse).
REQ-009 The module SHALL have port a_rdata, output, WIDTH bits: CPU read data.
REQ-010 The module SHALL have port a_rvalid, output, 1 bit: a_rdata is valid (one-cycle pulse).
REQ-011 The module SHALL have ports b_req, b_we, b_addr, b_wdata, b_gnt, b_rdata and b_rvalid with the same directions, widths and meanings as the a_ ports, serving the secondary requester (I/O, DMA or loader).
REQ-012 The module SHALL have port mem_addr, output, WIDTH bits: address to the single-port memory.
REQ-013 The module SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-014 The module SHALL have port mem_wdata, output, WIDTH bits: memory write data.
REQ-015 The module SHALL have port mem_rdata, input, WIDTH bits: memory read data, valid one clock after mem_addr is presented (synchronous RAM).

Function
REQ-016 The module SHALL implement an FSM with states IDLE, ACCESS_A, ACCESS_B, RESP_A and RESP_B.
REQ-017 In IDLE the module SHALL sample a_req and b_req: none -> stay in IDLE; one -> go to that port's ACCESS state; both -> go to the ACCESS state of the port not served last (round-robin).
REQ-018 On leaving IDLE the module SHALL latch the winner's we, addr and wdata into internal registers.
REQ-019 The module SHALL hold the round-robin pointer (last_served) in a register that updates on every grant and favours A after reset.
REQ-020 The winner's gnt SHALL be high for exactly the one cycle spent in its ACCESS state; a requester SHALL hold req, we, addr and wdata stable until it sees gnt.
REQ-021 In ACCESS_x the module SHALL drive mem_addr from the latched address and mem_wdata from the latched data, and SHALL drive mem_we = latched we.
REQ-022 mem_we SHALL be 0 in every state other than ACCESS_x.
REQ-023 After ACCESS_x: a write SHALL return to IDLE (2 cycles total); a read SHALL go to RESP_x.
REQ-024 In RESP_x the module SHALL copy mem_rdata into x_rdata and pulse x_rvalid for one cycle, then return to IDLE (3 cycles total per read).
REQ-025 x_rdata SHALL hold its last value until the next read response to that port.
REQ-026 mem_addr and mem_wdata SHALL keep their latched values outside ACCESS; no combinational path SHALL exist from any req to any mem_ output.
REQ-027 The module SHALL sample requests only in IDLE; a req withdrawn before its gnt SHALL be dropped with no memory access.
REQ-028 A req held high after gnt SHALL be treated as a new request at the next IDLE.
REQ-029 Under continuous requests from both ports the module SHALL alternate A, B, A, B, ...; no port SHALL wait more than one other transaction.
REQ-030 Addresses SHALL pass through unmodified, with no wrap-around or range checks (full WIDTH).

Reset
REQ-031 While reset is high, the module SHALL force state to IDLE, all gnt, rvalid and mem_we outputs to 0, mem_addr, mem_wdata, a_rdata and b_rdata to 0, and last_served to B (so A wins first).
REQ-032 A reset asserted mid-transaction SHALL abort that transaction, with no rvalid and no further mem_we; mem_we SHALL drop asynchronously.

Structure
REQ-033 State encoding localparams and the default WIDTH SHALL reside in the shared package mem_arb_pkg.
REQ-034 The block SHALL be a single flat module with no sub-module; the port mux is inline.

Verification
REQ-035 The bench SHALL cover: reset released; a_req=1, a_we=1, a_addr=0x0010, a_wdata=0xBEEF -> a_gnt pulses one cycle later; mem_we=1 and mem_addr=0x0010 in that cycle; IDLE the next cycle.
REQ-036 The bench SHALL cover: b_req read at 0x0010 after that write -> b_gnt, then b_rvalid=1 with b_rdata=0xBEEF two cycles after b_gnt; a_rvalid stays 0.
REQ-037 The bench SHALL cover: a_req and b_req both held high with reads for 8 transactions -> grant order A, B, A, B, ...; each read takes 3 cycles.
REQ-038 The bench SHALL cover: b_req raised during an A transaction and dropped before IDLE -> b_gnt never asserts and no memory access occurs for B.
REQ-039 The bench SHALL cover: reset asserted in the ACCESS_A cycle of a write -> mem_we=0 immediately; after release, state is IDLE and no a_rvalid appears.
REQ-040 The bench SHALL cover: simultaneous requests on the first cycle after reset -> A is granted first.
